// File: rtl/axi_burst_beat_gen_pkg.sv
// Shared types and constants for the AXI burst beat generator.
// BOUNDARY_4K_CHECK_EN (see axi_burst_beat_gen.sv) uses PAGE_4K from here.
package axi_burst_beat_gen_pkg;

  typedef enum logic [1:0] {
    FIXED    = 2'b00,
    INCR     = 2'b01,
    WRAP     = 2'b10,
    RESERVED = 2'b11
  } burst_name;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_name;

  typedef enum logic {
    IDLE = 1'b0,
    BEAT = 1'b1
  } beat_gen_state_e;

  localparam int unsigned PAGE_4K = 4096;

  // WRAP bursts must carry 2, 4, 8 or 16 beats; any other len is illegal.
  function automatic logic wrap_len_legal(input logic [31:0] len);
    return len inside {32'd1, 32'd3, 32'd7, 32'd15};
  endfunction

endpackage

// File: rtl/axi_burst_beat_gen_if.sv
// Request / beat-stream bundle between the AXI front end, the beat
// generator and the APB transfer sequencer.
interface axi_burst_beat_gen_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 9,
  parameter int LEN_WIDTH  = 8
);
  localparam int STRB_W = DATA_WIDTH / 8;

  // Both channels use valid/ready: a transfer occurs on a rising clock edge
  // where valid && ready; once valid is high, the payload holds until then.
  logic                  req_valid;
  logic                  req_ready;
  logic [ID_WIDTH-1:0]   req_id;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [LEN_WIDTH-1:0]  req_len;
  logic [2:0]            req_size;
  logic [1:0]            req_burst;

  logic                  beat_valid;
  logic                  beat_ready;
  logic [ID_WIDTH-1:0]   beat_id;
  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [STRB_W-1:0]     beat_strb;
  logic [LEN_WIDTH-1:0]  beat_idx;
  logic                  beat_last;
  logic                  beat_err;
  logic [1:0]            beat_resp;
  logic                  busy;

  modport master (
    output req_valid, req_id, req_addr, req_len, req_size, req_burst, beat_ready,
    input  req_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx,
           beat_last, beat_err, beat_resp, busy
  );

  modport slave (
    input  req_valid, req_id, req_addr, req_len, req_size, req_burst, beat_ready,
    output req_ready, beat_valid, beat_id, beat_addr, beat_strb, beat_idx,
           beat_last, beat_err, beat_resp, busy
  );
endinterface

// File: rtl/axi_burst_beat_strb.sv
// Byte-lane strobe for one beat: lanes from the address offset to the end of
// the size-aligned window, clipped to the bus width.
module axi_beat_strb #(
  parameter int DATA_WIDTH = 32,
  localparam int STRB_W = DATA_WIDTH / 8,
  localparam int OFF_W  = $clog2(STRB_W)
) (
  input  logic [OFF_W-1:0]  addr_lo,
  input  logic [2:0]        size,
  output logic [STRB_W-1:0] strb
);
  logic [31:0] bytes;
  logic [31:0] off;
  logic [31:0] win_end;

  always_comb begin
    bytes   = 32'd1 << size;
    off     = 32'(addr_lo);
    win_end = (off & ~(bytes - 32'd1)) + bytes;
    strb    = '0;
    for (int i = 0; i < STRB_W; i++) begin
      strb[i] = (32'(i) >= off) && (32'(i) < win_end);
    end
  end
endmodule

// File: rtl/axi_burst_beat_gen.sv
// Expands one AXI address-phase request into a per-beat stream (FIXED/INCR/WRAP).
// Define BOUNDARY_4K_CHECK_EN to reject INCR bursts that cross a 4 KB page.
module axi_burst_beat_gen
  import axi_burst_beat_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 9,
  parameter int LEN_WIDTH  = 8
) (
  input  logic             aclk,
  input  logic             aresetn,
  axi_burst_beat_gen_if.slave bus,
  output beat_gen_state_e  dbg_state
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int TOT_W  = LEN_WIDTH + 8;
  localparam logic [ADDR_WIDTH-1:0] ONE = 1;

  beat_gen_state_e       state;
  logic                  req_ready_q, busy_q;
  logic                  beat_valid_q, beat_last_q, beat_err_q;
  logic [ID_WIDTH-1:0]   beat_id_q;
  logic [ADDR_WIDTH-1:0] beat_addr_q;
  logic [STRB_W-1:0]     beat_strb_q;
  logic [LEN_WIDTH-1:0]  beat_idx_q, len_q;
  logic [1:0]            beat_resp_q, burst_q;
  logic [2:0]            size_q;
  logic [ADDR_WIDTH-1:0] bytes_q, wrap_lo_q, wrap_hi_q;

  logic [ADDR_WIDTH-1:0] bytes_in, aligned_in, total_a, wrap_lo_in, wrap_hi_in;
  logic [TOT_W-1:0]      total_in;
  logic                  illegal;
  logic [ADDR_WIDTH-1:0] wrap_inc, next_addr;
  logic [LEN_WIDTH-1:0]  idx_next;
  logic [OFF_W-1:0]      strb_lo;
  logic [2:0]            strb_size;
  logic [STRB_W-1:0]     strb_next;
`ifdef BOUNDARY_4K_CHECK_EN
  logic [ADDR_WIDTH-1:0] last_byte;
`endif

  always_comb begin
    bytes_in   = ONE << bus.req_size;
    aligned_in = bus.req_addr & ~(bytes_in - ONE);
    total_in   = (TOT_W'(bus.req_len) + TOT_W'(1)) << bus.req_size;
    total_a    = ADDR_WIDTH'(total_in);
    wrap_lo_in = bus.req_addr & ~(total_a - ONE);
    wrap_hi_in = wrap_lo_in + total_a;
    illegal    = (bus.req_burst == RESERVED) ||
                 (bytes_in > ADDR_WIDTH'(STRB_W)) ||
                 ((bus.req_burst == WRAP) &&
                  (!wrap_len_legal(32'(bus.req_len)) || (bus.req_addr != aligned_in)));
`ifdef BOUNDARY_4K_CHECK_EN
    last_byte = aligned_in + total_a - ONE;
    if ((bus.req_burst == INCR) &&
        (((last_byte ^ bus.req_addr) & ~ADDR_WIDTH'(PAGE_4K - 1)) != '0)) begin
      illegal = 1'b1;
    end
`endif
  end

  // Next beat address; INCR realigns so only beat0 can be unaligned.
  always_comb begin
    wrap_inc = beat_addr_q + bytes_q;
    idx_next = beat_idx_q + LEN_WIDTH'(1);
    case (burst_q)
      FIXED:   next_addr = beat_addr_q;
      WRAP:    next_addr = (wrap_inc == wrap_hi_q) ? wrap_lo_q : wrap_inc;
      default: next_addr = (beat_addr_q & ~(bytes_q - ONE)) + bytes_q;
    endcase
    strb_lo   = (state == IDLE) ? bus.req_addr[OFF_W-1:0] : next_addr[OFF_W-1:0];
    strb_size = (state == IDLE) ? bus.req_size : size_q;
  end

  axi_beat_strb #(.DATA_WIDTH(DATA_WIDTH)) u_strb (
    .addr_lo (strb_lo),
    .size    (strb_size),
    .strb    (strb_next)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state        <= IDLE;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_last_q  <= 1'b0;
      beat_err_q   <= 1'b0;
      beat_id_q    <= '0;
      beat_addr_q  <= '0;
      beat_strb_q  <= '0;
      beat_idx_q   <= '0;
      beat_resp_q  <= OKAY;
      len_q        <= '0;
      burst_q      <= '0;
      size_q       <= '0;
      bytes_q      <= '0;
      wrap_lo_q    <= '0;
      wrap_hi_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            state        <= BEAT;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            beat_valid_q <= 1'b1;
            beat_id_q    <= bus.req_id;
            beat_addr_q  <= bus.req_addr;
            beat_idx_q   <= '0;
            beat_err_q   <= illegal;
            beat_resp_q  <= illegal ? DECERR : OKAY;
            beat_last_q  <= illegal || (bus.req_len == '0);
            beat_strb_q  <= illegal ? '0 : strb_next;
            len_q        <= bus.req_len;
            burst_q      <= bus.req_burst;
            size_q       <= bus.req_size;
            bytes_q      <= bytes_in;
            wrap_lo_q    <= wrap_lo_in;
            wrap_hi_q    <= wrap_hi_in;
          end
        end
        BEAT: begin
          if (bus.beat_ready) begin
            if (beat_last_q) begin
              state        <= IDLE;
              req_ready_q  <= 1'b1;
              busy_q       <= 1'b0;
              beat_valid_q <= 1'b0;
              beat_last_q  <= 1'b0;
              beat_err_q   <= 1'b0;
              beat_id_q    <= '0;
              beat_addr_q  <= '0;
              beat_strb_q  <= '0;
              beat_idx_q   <= '0;
              beat_resp_q  <= OKAY;
            end else begin
              beat_addr_q <= next_addr;
              beat_idx_q  <= idx_next;
              beat_strb_q <= strb_next;
              beat_last_q <= (idx_next == len_q);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.busy       = busy_q;
  assign bus.beat_valid = beat_valid_q;
  assign bus.beat_id    = beat_id_q;
  assign bus.beat_addr  = beat_addr_q;
  assign bus.beat_strb  = beat_strb_q;
  assign bus.beat_idx   = beat_idx_q;
  assign bus.beat_last  = beat_last_q;
  assign bus.beat_err   = beat_err_q;
  assign bus.beat_resp  = beat_resp_q;
  assign dbg_state      = state;
endmodule
